prio_encoder_sync: RTL and testbench
====================================

PRIO_ENCODER_SYNC -- requirements
Module: prio_encoder_sync

Interface
REQ-001 Parameter N, default 4: number of request lines; legal range 2..32.
REQ-002 Parameter DEBOUNCE, default 4: cycles a candidate code must stay stable before commit; legal range 1..255.
REQ-003 Parameter MSB_FIRST, default 1: 1 = highest set index wins, 0 = lowest set index wins.
REQ-004 Derived QW = $clog2(N+1): output code width (3 for N=4).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-high.
REQ-007 data  input  N  asynchronous request lines; bit i set = source i requesting.
REQ-008 lock  input  1  synchronous freeze; while high, no new code is accepted.
REQ-009 q  output  QW  committed code: 0 = no request, i+1 = source i selected.
REQ-010 q_chg  output  1  one-cycle pulse on the cycle q takes a new value.
REQ-011 multi  output  1  high while the committed code came from a multi-hot input.
REQ-012 busy  output  1  high while a candidate is being debounced (state PENDING).

Function
REQ-013 data shall pass through a 2-flop synchroniser (s1, s2); all decisions use s2 only.
REQ-014 Candidate cand = 0 when s2 == 0; otherwise cand = (index of winning set bit per MSB_FIRST) + 1.
REQ-015 Candidate multi flag cmulti = 1 when s2 has two or more bits set.
REQ-016 State machine has two states: STABLE and PENDING; counter cnt has width $clog2(DEBOUNCE+1).
REQ-017 STABLE, lock=0, cand != q: go to PENDING, pend <= cand, pmulti <= cmulti, cnt <= 1.
REQ-018 STABLE, cand == q: remain STABLE, multi <= cmulti (tracks multi-hot change without code change), no q_chg.
REQ-019 PENDING, cand == pend, cnt < DEBOUNCE: cnt <= cnt+1.
REQ-020 PENDING, cand == pend, cnt == DEBOUNCE: q <= pend, multi <= pmulti, q_chg <= 1 for exactly one cycle, go to STABLE, cnt <= 0.
REQ-021 PENDING, cand != pend, cand == q: abandon, go to STABLE, cnt <= 0, q unchanged, no q_chg.
REQ-022 PENDING, cand != pend, cand != q: restart, pend <= cand, pmulti <= cmulti, cnt <= 1.
REQ-023 lock=1 in any state: go to or remain STABLE, cnt <= 0, q and multi held, q_chg = 0; lock has priority over REQ-019..022 including the commit cycle.
REQ-024 Latency: a steady data change set up before edge 0 yields new q and q_chg high after edge DEBOUNCE+2 (edge 6 at default).
REQ-025 Input pulses shorter than DEBOUNCE+1 cycles at s2 shall never change q.
REQ-026 busy = (state == PENDING); q_chg, busy and multi are registered or decoded from registers only, no combinational path from data or lock.
REQ-027 cnt shall never exceed DEBOUNCE; no wrap-around is possible.

Reset
REQ-028 On rst high, immediately: s1=s2=0, state=STABLE, cnt=0, pend=0, q=0, q_chg=0, multi=0, busy=0.
REQ-029 Reset asserted mid-PENDING discards the candidate; first commit after release follows REQ-024 timing from the release edge.
REQ-030 With data held at 0 through and after reset, no q_chg shall ever occur.

Verification (N=4, DEBOUNCE=4 unless stated)
REQ-031 Single-hot sweep: data 0001, 0010, 0100, 1000 each held 10 cycles -> q = 1, 2, 3, 4 respectively, one q_chg each, q updates exactly 6 edges after data change.
REQ-032 Multi-hot priority: data 0110 held -> MSB_FIRST=1 gives q=3, multi=1; MSB_FIRST=0 build gives q=2, multi=1.
REQ-033 Glitch rejection: from q=1, data 0100 for 3 cycles then back to 0001 -> busy pulses, q stays 1, no q_chg.
REQ-034 Lock: lock=1, data 0000 -> 1000 for 20 cycles -> q unchanged, busy 0; lock released -> q=4 after DEBOUNCE+1 edges (input already synchronised), one q_chg.
REQ-035 Async reset: rst pulsed between clock edges while PENDING -> all outputs 0 before next edge; data 0010 held after release -> q=2 at edge 6 after release.
REQ-036 DEBOUNCE=1 build: data 0001 -> q=1 after edge 3, single q_chg.

Source files
------------

// File: rtl/prio_encoder_sync.sv
// prio_encoder_sync
//   Synchronised, debounced priority encoder. The asynchronous request lines
//   pass through a two-flop synchroniser. A priority code (candidate) is
//   derived from the synchronised value. The candidate is committed to q only
//   after it has stayed unchanged for DEBOUNCE further cycles. While lock is
//   high, no new code is accepted.
//
// Parameters
//   N          number of request lines (2..32)
//   DEBOUNCE   cycles a candidate must stay stable before commit (1..255)
//   MSB_FIRST  1: highest set index wins, 0: lowest set index wins
//
// Ports
//   clk    in   single clock, rising-edge
//   rst    in   asynchronous active-high reset
//   data   in   [N-1:0] asynchronous request lines
//   lock   in   synchronous freeze, no new code accepted while high
//   q      out  [QW-1:0] committed code, 0 = none, i+1 = source i
//   q_chg  out  one-cycle pulse on the cycle q takes a new value
//   multi  out  committed code came from a multi-hot input
//   busy   out  a candidate is being debounced
module prio_encoder_sync #(
  parameter int N         = 4,
  parameter int DEBOUNCE  = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int QW       = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  data,
  input  logic          lock,
  output logic [QW-1:0] q,
  output logic          q_chg,
  output logic          multi,
  output logic          busy
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Winning index + 1. The scan order makes the last hit the winner.
  function automatic logic [QW-1:0] encode(input logic [N-1:0] v);
    logic [QW-1:0] code;
    code = {QW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (MSB_FIRST) begin
        code = v[i] ? QW'(i + 1) : code;
      end else begin
        code = v[N-1-i] ? QW'(N - i) : code;
      end
    end
    return code;
  endfunction

  // v & (v-1) clears the lowest set bit. A non-zero result means two or more bits are set.
  function automatic logic is_multi(input logic [N-1:0] v);
    return (v & (v - {{(N-1){1'b0}}, 1'b1})) != {N{1'b0}};
  endfunction

  logic [N-1:0]  s1_r;
  logic [N-1:0]  s2_r;
  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [QW-1:0] pend_r;
  logic [QW-1:0] pend_s;
  logic          pmulti_r;
  logic          pmulti_s;
  logic [QW-1:0] q_r;
  logic [QW-1:0] q_s;
  logic          multi_r;
  logic          multi_s;
  logic          q_chg_r;
  logic          q_chg_s;
  logic [QW-1:0] cand_s;
  logic          cmulti_s;

  // Two-flop synchroniser on the asynchronous request lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= {N{1'b0}};
      s2_r <= {N{1'b0}};
    end else begin
      s1_r <= data;
      s2_r <= s1_r;
    end
  end

  // Candidate code and multi-hot flag from the synchronised lines only
  always_comb begin
    cand_s   = encode(s2_r);
    cmulti_s = is_multi(s2_r);
  end

  // Debounce state machine: next-state and next-output decode
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pend_s   = pend_r;
    pmulti_s = pmulti_r;
    q_s      = q_r;
    multi_s  = multi_r;
    q_chg_s  = 1'b0;
    if (lock) begin
      // Freeze wins over everything, including a commit due this cycle.
      state_s = STABLE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        STABLE: begin
          if (cand_s != q_r) begin
            state_s  = PENDING;
            pend_s   = cand_s;
            pmulti_s = cmulti_s;
            cnt_s    = CNT_ONE;
          end else begin
            // Same code, but the multi-hot status may still change.
            multi_s = cmulti_s;
          end
        end
        PENDING: begin
          if (cand_s == pend_r) begin
            // >= keeps cnt bounded even if it were ever corrupted.
            if (cnt_r >= CNT_MAX) begin
              q_s     = pend_r;
              multi_s = pmulti_r;
              q_chg_s = 1'b1;
              state_s = STABLE;
              cnt_s   = CNT_ZERO;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else if (cand_s == q_r) begin
            // Input fell back to the committed code: drop the candidate.
            state_s = STABLE;
            cnt_s   = CNT_ZERO;
          end else begin
            pend_s   = cand_s;
            pmulti_s = cmulti_s;
            cnt_s    = CNT_ONE;
          end
        end
        default: begin
          state_s = STABLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= STABLE;
      cnt_r    <= CNT_ZERO;
      pend_r   <= {QW{1'b0}};
      pmulti_r <= 1'b0;
      q_r      <= {QW{1'b0}};
      multi_r  <= 1'b0;
      q_chg_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      pend_r   <= pend_s;
      pmulti_r <= pmulti_s;
      q_r      <= q_s;
      multi_r  <= multi_s;
      q_chg_r  <= q_chg_s;
    end
  end

  assign q     = q_r;
  assign q_chg = q_chg_r;
  assign multi = multi_r;
  assign busy  = (state_r == PENDING);

endmodule

// File: tb/tb_prio_encoder_sync.sv
// Testbench for prio_encoder_sync. It runs three builds side by side on the
// same inputs: the default build, an LSB-first build and a DEBOUNCE=1 build.
// A run-length reference model checks every cycle. Directed table steps and
// hand-written sequences check fixed expected values.
module tb_prio_encoder_sync;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       lock;
  logic [2:0] dq     [NI];
  logic       dchg   [NI];
  logic       dmulti [NI];
  logic       dbusy  [NI];

  int n_cmp  = 0;
  int n_fail = 0;
  int chg_cnt  [NI];
  int busy_cnt [NI];

  // Reference model state
  logic [3:0] m_s1;
  logic [3:0] m_s2;
  int m_q    [NI];
  bit m_multi[NI];
  bit m_pend [NI];
  bit m_chg  [NI];
  int m_run  [NI];
  int m_prev [NI];
  bit m_smul [NI];

  always #5 clk = ~clk;

  prio_encoder_sync #(.N(4), .DEBOUNCE(4), .MSB_FIRST(1'b1)) u_main (
    .clk(clk), .rst(rst), .data(data), .lock(lock),
    .q(dq[0]), .q_chg(dchg[0]), .multi(dmulti[0]), .busy(dbusy[0]));

  prio_encoder_sync #(.N(4), .DEBOUNCE(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data(data), .lock(lock),
    .q(dq[1]), .q_chg(dchg[1]), .multi(dmulti[1]), .busy(dbusy[1]));

  prio_encoder_sync #(.N(4), .DEBOUNCE(1), .MSB_FIRST(1'b1)) u_deb1 (
    .clk(clk), .rst(rst), .data(data), .lock(lock),
    .q(dq[2]), .q_chg(dchg[2]), .multi(dmulti[2]), .busy(dbusy[2]));

  function automatic int deb_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  // Code from arithmetic: highest bit via $clog2(v+1), lowest via v & -v
  function automatic int ref_code(input int k, input logic [3:0] v);
    logic [3:0] low;
    if (v == 4'd0) return 0;
    if (k != 1) return $clog2(int'(v) + 1);
    low = v & (~v + 4'd1);
    return $clog2(int'(low)) + 1;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // A candidate commits once it has been seen on DEBOUNCE+1 consecutive
  // unlocked edges while differing from the committed code.
  task automatic monitor();
    int c;
    bit cm;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = 4'd0;
        m_s2 = 4'd0;
        for (int k = 0; k < NI; k++) begin
          m_q[k] = 0; m_multi[k] = 1'b0; m_pend[k] = 1'b0; m_chg[k] = 1'b0;
          m_run[k] = 0; m_prev[k] = 0; m_smul[k] = 1'b0;
        end
        #1;
      end else begin
        for (int k = 0; k < NI; k++) begin
          c  = ref_code(k, m_s2);
          cm = ($countones(m_s2) >= 2);
          m_chg[k] = 1'b0;
          if (lock) begin
            m_run[k]  = 0;
            m_pend[k] = 1'b0;
          end else begin
            if (m_run[k] > 0 && c == m_prev[k]) begin
              m_run[k]++;
            end else begin
              m_run[k]  = 1;
              m_smul[k] = cm;
            end
            if (c == m_q[k]) begin
              if (!m_pend[k]) m_multi[k] = cm;
              m_pend[k] = 1'b0;
            end else if (m_run[k] == deb_of(k) + 1) begin
              m_q[k]     = c;
              m_multi[k] = m_smul[k];
              m_chg[k]   = 1'b1;
              m_pend[k]  = 1'b0;
            end else begin
              m_pend[k] = 1'b1;
            end
          end
          m_prev[k] = c;
        end
        m_s2 = m_s1;
        m_s1 = data;
        #3;
      end
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (int'(dq[k]) != m_q[k] || dmulti[k] !== m_multi[k] ||
            dchg[k] !== m_chg[k] || dbusy[k] !== m_pend[k]) begin
          n_fail++;
          $display("FAIL model[%0d] t=%0t: got q=%0d multi=%0d chg=%0d busy=%0d expected q=%0d multi=%0d chg=%0d busy=%0d",
                   k, $time, dq[k], dmulti[k], dchg[k], dbusy[k],
                   m_q[k], m_multi[k], m_chg[k], m_pend[k]);
        end
        chg_cnt[k]  += int'(dchg[k]);
        busy_cnt[k] += int'(dbusy[k]);
      end
    end
  endtask

  typedef struct {
    logic [3:0] d;
    int         q_main;
    int         m_main;
    int         chg_main;
    int         q_lsb;
    int         m_lsb;
  } vec_t;

  vec_t vecs[7];
  int   base_chg;
  int   base_busy;
  int   hold;

  initial begin
    for (int k = 0; k < NI; k++) begin
      chg_cnt[k]  = 0;
      busy_cnt[k] = 0;
    end
    rst  = 1'b1;
    data = 4'd0;
    lock = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with data held at zero: nothing may ever commit
    repeat (12) @(negedge clk);
    check("idle_no_qchg", chg_cnt[0] + chg_cnt[1] + chg_cnt[2], 0);
    check("idle_q", int'(dq[0]), 0);

    // First-commit latency, edges numbered from 0 after the data change
    data = 4'b0001;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) check("deb1_q_edge2", int'(dq[2]), 0);
      if (e == 3) check("deb1_q_edge3", int'(dq[2]), 1);
      if (e == 3) check("deb1_chg_edge3", int'(dchg[2]), 1);
      if (e == 5) check("main_q_edge5", int'(dq[0]), 0);
      if (e == 6) check("main_q_edge6", int'(dq[0]), 1);
      if (e == 6) check("main_chg_edge6", int'(dchg[0]), 1);
    end

    // Table steps, each held 10 cycles
    vecs[0] = '{4'b0010, 2, 0, 1, 2, 0};
    vecs[1] = '{4'b0100, 3, 0, 1, 3, 0};
    vecs[2] = '{4'b1000, 4, 0, 1, 4, 0};
    vecs[3] = '{4'b0110, 3, 1, 1, 2, 1};
    vecs[4] = '{4'b1011, 4, 1, 1, 1, 1};
    vecs[5] = '{4'b1000, 4, 0, 0, 4, 0};
    vecs[6] = '{4'b0001, 1, 0, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      base_chg = chg_cnt[0];
      data = vecs[i].d;
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d_q_main", i), int'(dq[0]), vecs[i].q_main);
      check($sformatf("vec%0d_multi_main", i), int'(dmulti[0]), vecs[i].m_main);
      check($sformatf("vec%0d_chg_main", i), chg_cnt[0] - base_chg, vecs[i].chg_main);
      check($sformatf("vec%0d_q_lsb", i), int'(dq[1]), vecs[i].q_lsb);
      check($sformatf("vec%0d_multi_lsb", i), int'(dmulti[1]), vecs[i].m_lsb);
    end

    // Glitch rejection: three-cycle pulse from q=1
    @(negedge clk);
    base_chg  = chg_cnt[0];
    base_busy = busy_cnt[0];
    data = 4'b0100;
    repeat (3) @(negedge clk);
    data = 4'b0001;
    repeat (10) @(negedge clk);
    check("glitch_q", int'(dq[0]), 1);
    check("glitch_chg", chg_cnt[0] - base_chg, 0);
    check("glitch_busy_cycles", busy_cnt[0] - base_busy, 3);

    // Lock: settle to q=0, then hold a new request under lock
    data = 4'b0000;
    repeat (10) @(negedge clk);
    lock = 1'b1;
    data = 4'b1000;
    base_chg  = chg_cnt[0];
    base_busy = busy_cnt[0];
    repeat (20) @(negedge clk);
    check("lock_q", int'(dq[0]), 0);
    check("lock_busy", busy_cnt[0] - base_busy, 0);
    check("lock_chg", chg_cnt[0] - base_chg, 0);
    lock = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) check("unlock_q_edge3", int'(dq[0]), 0);
      if (e == 4) check("unlock_q_edge4", int'(dq[0]), 4);
      if (e == 4) check("unlock_chg_edge4", int'(dchg[0]), 1);
    end

    // Async reset in the middle of PENDING
    @(negedge clk);
    data = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(dbusy[0]), 1);
    #6;
    rst = 1'b1;
    #1;
    check("rst_q", int'(dq[0]), 0);
    check("rst_busy", int'(dbusy[0]), 0);
    check("rst_multi_chg", int'(dmulti[0]) + int'(dchg[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) check("post_rst_q_edge5", int'(dq[0]), 0);
      if (e == 6) check("post_rst_q_edge6", int'(dq[0]), 2);
    end

    // Randomised traffic with occasional lock, checked by the model
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        if ($urandom_range(0, 3) != 0) data = 4'($urandom_range(0, 15));
        lock = ($urandom_range(0, 7) == 0);
        hold = $urandom_range(1, 8);
      end
      hold--;
    end
    lock = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
